// File: rtl/debug_dual_port_ram_if.sv
// debug_dual_port_ram_if
// Bus bundle for the dual-port instruction/data RAM.
//   Port 1 (A1/WD1/WE1/RD1): core fetch or load/store path.
//   Port 2 (A2/WD2/WE2/RD2): debug loader/dumper path.
//   A*  : byte address (word index taken from A[AW+1:2])
//   WD* : write data
//   WE* : per-byte write enables, bit n covers WD*[8n+7:8n]
//   RD* : registered read data, one cycle latency
// master modport drives requests, slave modport (the RAM) returns RD1/RD2.
interface debug_dual_port_ram_if;
    logic [31:0] A1;
    logic [31:0] WD1;
    logic [3:0]  WE1;
    logic [31:0] RD1;
    logic [31:0] A2;
    logic [31:0] WD2;
    logic [3:0]  WE2;
    logic [31:0] RD2;

    modport master (
        output A1, WD1, WE1, A2, WD2, WE2,
        input  RD1, RD2
    );

    modport slave (
        input  A1, WD1, WE1, A2, WD2, WE2,
        output RD1, RD2
    );
endinterface

// File: rtl/debug_dual_port_ram.sv
// debug_dual_port_ram
// Word-organised, byte-writable true dual-port RAM shared by the core
// (port 1) and the debug loader/dumper (port 2).
//   CPU_CLK : single clock, all state changes on the rising edge
//   CPU_RST : asynchronous active-high reset; clears RD1/RD2 at once and
//             blocks writes, but never clears the array
//   bus     : debug_dual_port_ram_if.slave carrying A1/WD1/WE1/RD1 and
//             A2/WD2/WE2/RD2
// Reads are synchronous and read-first: RDx shows the word as it stood
// before the same edge's writes. Address bits outside [AW+1:2] are
// ignored, so addresses alias modulo WORDS*4.
module debug_dual_port_ram #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = 12
) (
    input logic                  CPU_CLK,
    input logic                  CPU_RST,
    debug_dual_port_ram_if.slave bus
);

    logic [31:0]   mem [WORDS] = '{default: '0};
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic          sameIdx;
    logic [3:0]    we1Eff;
    logic [31:0]   rd1Q;
    logic [31:0]   rd2Q;
    logic          unusedAddrBits;

    assign idx1 = bus.A1[AW+1:2];
    assign idx2 = bus.A2[AW+1:2];

    assign unusedAddrBits = ^{bus.A1[31:AW+2], bus.A1[1:0],
                              bus.A2[31:AW+2], bus.A2[1:0]};

    // Debug port wins per byte on a same-word collision: port-1 enables are
    // masked wherever port 2 writes the same byte lane of the same word, so
    // the two write ports never target the same byte on one edge.
    always_comb begin
        sameIdx = 1'b0;
        we1Eff  = '0;
        sameIdx = (idx1 == idx2);
        we1Eff  = bus.WE1 & ~(bus.WE2 & {4{sameIdx}});
    end

    // Array has no reset: contents survive CPU_RST, only writes are gated.
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (we1Eff[n]) begin
                    mem[idx1][8*n +: 8] <= bus.WD1[8*n +: 8];
                end
                if (bus.WE2[n]) begin
                    mem[idx2][8*n +: 8] <= bus.WD2[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            rd1Q <= '0;
            rd2Q <= '0;
        end else begin
            rd1Q <= mem[idx1];
            rd2Q <= mem[idx2];
        end
    end

    assign bus.RD1 = rd1Q;
    assign bus.RD2 = rd2Q;

endmodule

// File: tb/tb_debug_dual_port_ram.sv
// tb_debug_dual_port_ram
// Scoreboard bench for debug_dual_port_ram: every driven cycle pushes the
// read data it expects on RD1/RD2 after the next rising edge; the values are
// popped and compared one time unit after that edge.
module tb_debug_dual_port_ram;

    typedef struct {
        string       tag;
        bit          port;
        logic [31:0] val;
    } ExpItem;

    logic CPU_CLK = 1'b0;
    logic CPU_RST = 1'b0;

    debug_dual_port_ram_if bus ();

    debug_dual_port_ram #(
        .WORDS (4096),
        .AW    (12)
    ) dut (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .bus     (bus)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int     checks = 0;
    int     errors = 0;
    ExpItem expQ[$];

    // small reference for the random phase: words 0x400..0x407
    logic [31:0] model [8];

    task automatic checkValue(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [31:0] a1, input logic [31:0] wd1,
                         input logic [3:0] we1, input logic [31:0] a2,
                         input logic [31:0] wd2, input logic [3:0] we2);
        @(negedge CPU_CLK);
        bus.A1  = a1;
        bus.WD1 = wd1;
        bus.WE1 = we1;
        bus.A2  = a2;
        bus.WD2 = wd2;
        bus.WE2 = we2;
    endtask

    task automatic expect1(input string tag, input logic [31:0] v);
        ExpItem e;
        e.tag = tag; e.port = 1'b0; e.val = v;
        expQ.push_back(e);
    endtask

    task automatic expect2(input string tag, input logic [31:0] v);
        ExpItem e;
        e.tag = tag; e.port = 1'b1; e.val = v;
        expQ.push_back(e);
    endtask

    task automatic tick();
        ExpItem e;
        @(posedge CPU_CLK);
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkValue(e.tag, e.port ? bus.RD2 : bus.RD1, e.val);
        end
    endtask

    initial begin
        logic [11:0] i1, i2;
        logic [31:0] a1, a2, wd1, wd2;
        logic [3:0]  we1, we2;

        bus.A1 = '0; bus.WD1 = '0; bus.WE1 = '0;
        bus.A2 = '0; bus.WD2 = '0; bus.WE2 = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        // reset state
        #2 CPU_RST = 1'b1;
        #1;
        checkValue("rst_rd1", bus.RD1, 32'h0);
        checkValue("rst_rd2", bus.RD2, 32'h0);
        @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;

        // 1. basic write/read
        drive(32'h0, 32'h0, 4'h0, 32'h10, 32'hDEADBEEF, 4'hF);
        expect2("t1_old", 32'h0);
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h10, 32'h0, 4'h0);
        expect2("t1_rd2", 32'hDEADBEEF);
        expect1("t1_rd1", 32'hDEADBEEF);
        tick();

        // 2. byte enables
        drive(32'h0, 32'h0, 4'h0, 32'h20, 32'h11223344, 4'hF);
        tick();
        drive(32'h20, 32'hAABBCCDD, 4'b0101, 32'h100, 32'h0, 4'h0);
        expect1("t2_rdfirst", 32'h11223344);
        tick();
        drive(32'h20, 32'h0, 4'h0, 32'h20, 32'h0, 4'h0);
        expect1("t2_rd1", 32'h11BB33DD);
        expect2("t2_rd2", 32'h11BB33DD);
        tick();

        // 3. wrap / alias
        drive(32'h0, 32'h0BADF00D, 4'hF, 32'hFFFFFFFC, 32'h5A5A0001, 4'hF);
        tick();
        drive(32'h00004000, 32'h0, 4'h0, 32'h00003FFC, 32'h0, 4'h0);
        expect2("t3_3ffc", 32'h5A5A0001);
        expect1("t3_4000", 32'h0BADF00D);
        tick();
        drive(32'h00000003, 32'h0, 4'h0, 32'h00003FFF, 32'h0, 4'h0);
        expect2("t3_3fff", 32'h5A5A0001);
        expect1("t3_w0", 32'h0BADF00D);
        tick();
        drive(32'hFFFFFFFF, 32'h0, 4'h0, 32'h00004000, 32'h0, 4'h0);
        expect2("t3_a2_4000", 32'h0BADF00D);
        expect1("t3_ffff", 32'h5A5A0001);
        tick();

        // 4. collision, port 2 wins on shared bytes
        drive(32'h40, 32'h11111111, 4'hF, 32'h40, 32'h22222222, 4'b0011);
        tick();
        drive(32'h40, 32'h0, 4'h0, 32'h40, 32'h0, 4'h0);
        expect1("t4_rd1", 32'h11112222);
        expect2("t4_rd2", 32'h11112222);
        tick();

        // 5. read-first across ports
        drive(32'h0, 32'h0, 4'h0, 32'h80, 32'h1, 4'hF);
        tick();
        drive(32'h80, 32'h2, 4'hF, 32'h80, 32'h0, 4'h0);
        expect2("t5_old", 32'h1);
        expect1("t5_sameport_old", 32'h1);
        tick();
        drive(32'h80, 32'h0, 4'h0, 32'h80, 32'h0, 4'h0);
        expect2("t5_new", 32'h2);
        expect1("t5_new1", 32'h2);
        tick();

        // different indices written on one edge
        drive(32'h200, 32'hA1A1A1A1, 4'hF, 32'h300, 32'hB2B2B2B2, 4'hF);
        tick();
        drive(32'h300, 32'h0, 4'h0, 32'h200, 32'h0, 4'h0);
        expect1("dual_rd1", 32'hB2B2B2B2);
        expect2("dual_rd2", 32'hA1A1A1A1);
        tick();

        // 6. reset between edges
        drive(32'h10, 32'h0, 4'h0, 32'h20, 32'h0, 4'h0);
        expect1("t6_pre1", 32'hDEADBEEF);
        expect2("t6_pre2", 32'h11BB33DD);
        tick();
        #2 CPU_RST = 1'b1;
        #1;
        checkValue("t6_async_rd1", bus.RD1, 32'h0);
        checkValue("t6_async_rd2", bus.RD2, 32'h0);
        drive(32'h10, 32'h0, 4'h0, 32'h10, 32'hFFFFFFFF, 4'hF);
        expect2("t6_inrst_rd2", 32'h0);
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h10, 32'h0, 4'h0);
        CPU_RST = 1'b0;
        #1;
        checkValue("t6_hold_rd1", bus.RD1, 32'h0);
        expect1("t6_after1", 32'hDEADBEEF);
        expect2("t6_after2", 32'hDEADBEEF);
        tick();

        // random traffic on words 0x400..0x407 with aliased upper/low bits
        for (int c = 0; c < 200; c++) begin
            i1  = 12'h400 + 12'($urandom_range(0, 7));
            i2  = 12'h400 + 12'($urandom_range(0, 7));
            a1  = {18'($urandom), i1, 2'($urandom)};
            a2  = {18'($urandom), i2, 2'($urandom)};
            wd1 = $urandom;
            wd2 = $urandom;
            we1 = 4'($urandom);
            we2 = 4'($urandom);
            drive(a1, wd1, we1, a2, wd2, we2);
            expect1("rnd_rd1", model[i1[2:0]]);
            expect2("rnd_rd2", model[i2[2:0]]);
            for (int n = 0; n < 4; n++) begin
                if (we1[n]) model[i1[2:0]][8*n +: 8] = wd1[8*n +: 8];
            end
            for (int n = 0; n < 4; n++) begin
                if (we2[n]) model[i2[2:0]][8*n +: 8] = wd2[8*n +: 8];
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_dual_port_ram.md
Name: debug_dual_port_ram

Overview:
- Word-organised, byte-writable data/instruction memory that answers two independent masters.
- Port 1 serves the RV32 core's fetch or load/store path. Port 2 serves the debug loader/dumper, which fills memory before execution and reads it back afterwards.
- One instance backs InstRAM and one backs DataRAM inside RV32Core; the debug side is the CPU_Debug_*RAM_*2 bus.

Parameters:
- WORDS, 4096, number of 32-bit words; must be a power of two.
- AW, 12, word-index width; must equal log2(WORDS).

Ports:
- CPU_CLK  in  1  single clock; all state updates on rising edge.
- CPU_RST  in  1  asynchronous, active-high reset.
- A1  in  32  port-1 byte address.
- WD1  in  32  port-1 write data.
- WE1  in  4  port-1 byte write enables; bit n covers WD1[8n+7:8n].
- RD1  out  32  port-1 registered read data.
- A2  in  32  debug byte address.
- WD2  in  32  debug write data.
- WE2  in  4  debug byte write enables.
- RD2  out  32  debug registered read data.

Behaviour:
- Addressing:
  - Word index = A[AW+1:2].
  - A[1:0] and A[31:AW+2] are ignored, so addresses alias modulo WORDS*4. For example, 0xFFFFFFFC maps to index WORDS-1, and +4 wraps to index 0.
- Reset:
  - While CPU_RST=1, RD1 and RD2 are forced to 32'h0 immediately, without waiting for a clock edge.
  - All writes are suppressed while CPU_RST=1.
  - Array contents are NOT cleared by reset and are retained across reset pulses.
  - Array power-up content is 0 (simulation init).
- Read timing:
  - Synchronous read, latency 1. On rising edge k, RDx takes mem[index(Ax)] as it stood before edge k's writes (read-first).
  - RDx holds its value until the next edge; there is no read enable, so a read occurs every cycle.
- Write timing:
  - On a rising edge with CPU_RST=0, each byte n with WEx[n]=1 is written from WDx byte n.
  - Bytes with WEx[n]=0 are untouched.
  - A partial write takes one cycle; there is no read-modify-write stall.
- Same-port write+read: RDx returns the old word; the new value is visible on the following edge's read.
- Cross-port read of a word being written by the other port in the same cycle: returns the old word.
- Write collision (both ports, same index, same edge):
  - Per byte: if both enables are set, port 2 (debug) wins.
  - Bytes enabled on only one port are written from that port.
- Writes to different indices on the same edge are both applied.
- No handshake: both ports accept a new request every cycle, with fixed latency and no back-pressure.
- Reset release mid-access: the first edge after CPU_RST falls performs a normal read/write. RD shows 0 until that edge.
- Structure: synthesizable as true dual-port BRAM with byte enables. The collision rule is implemented with explicit per-byte priority logic, not left to the tool.

Test Plan:
1. Basic write/read:
   - Stimulus: reset, then port 2 writes WD2=0xDEADBEEF, WE2=4'hF at A2=0x10; next cycle A2=0x10, WE2=0.
   - Required: RD2=0xDEADBEEF one edge later. RD1 at A1=0x10 also returns 0xDEADBEEF.
2. Byte enables:
   - Stimulus: preload 0x11223344 at 0x20, then port 1 writes WD1=0xAABBCCDD, WE1=4'b0101.
   - Required: readback 0x11BB33DD.
3. Wrap/alias:
   - Stimulus: write 0x5A5A0001 at A2=0xFFFFFFFC, then read at A2=0x00003FFC and at A2=0x00003FFF.
   - Required: both return 0x5A5A0001 (WORDS=4096). A2=0x00004000 reads word 0.
4. Collision:
   - Stimulus: same edge, port 1 writes 0x11111111 with WE1=4'hF and port 2 writes 0x22222222 with WE2=4'b0011, both at 0x40.
   - Required: readback 0x11112222.
5. Read-first:
   - Stimulus: mem[0x80]=0x1; port 1 writes 0x2 at 0x80 while port 2 reads 0x80 in the same cycle.
   - Required: RD2=0x1, then 0x2 on the next edge.
6. Reset:
   - Stimulus: with RD1=0xDEADBEEF, assert CPU_RST between clock edges.
   - Required: RD1=0 immediately. WE2=4'hF during reset leaves the target word unchanged. After release, the previously written data still reads back intact.
